// File: rtl/emif_calbus_dbg_arb.sv
// emif_calbus_dbg_arb: forwards calibration-IP calbus traffic to the EMIF
// with zero added latency and slips single debug accesses into guaranteed
// idle windows. Also returns the sequencer parameter table and keeps
// saturating counts of calibration reads and writes.
module emif_calbus_dbg_arb #(
   parameter int RD_LAT   = 2,
   parameter int IDLE_GAP = 4
) (
   input  logic          calbus_clk,
   input  logic          calbus_rst_n,
   input  logic          cal_read,
   input  logic          cal_write,
   input  logic [19:0]   cal_address,
   input  logic [31:0]   cal_wdata,
   output logic [31:0]   cal_rdata,
   output logic [4095:0] cal_seq_param_tbl,
   output logic          emif_calbus_read,
   output logic          emif_calbus_write,
   output logic [19:0]   emif_calbus_address,
   output logic [31:0]   emif_calbus_wdata,
   input  logic [31:0]   emif_calbus_rdata,
   input  logic [4095:0] emif_calbus_seq_param_tbl,
   input  logic          dbg_req,
   input  logic          dbg_wr,
   input  logic [19:0]   dbg_addr,
   input  logic [31:0]   dbg_wdata,
   output logic          dbg_busy,
   output logic          dbg_ack,
   output logic [31:0]   dbg_rdata,
   output logic [15:0]   cal_rd_cnt,
   output logic [15:0]   cal_wr_cnt
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ISSUE  = 2'd1;
   localparam logic [1:0] ST_RDWAIT = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   localparam logic [7:0] GAP      = 8'(IDLE_GAP);
   localparam logic [3:0] LAT_INIT = 4'(RD_LAT - 1);

   logic [1:0]  state_q,     state_d;
   logic [7:0]  idle_cnt_q,  idle_cnt_d;
   logic [3:0]  lat_cnt_q,   lat_cnt_d;
   logic        dbg_wr_q,    dbg_wr_d;
   logic [19:0] dbg_addr_q,  dbg_addr_d;
   logic [31:0] dbg_wdata_q, dbg_wdata_d;
   logic [31:0] dbg_rdata_q, dbg_rdata_d;
   logic        dbg_busy_q,  dbg_busy_d;
   logic        dbg_ack_q,   dbg_ack_d;
   logic        issue_arm_q, issue_arm_d;
   logic [15:0] cal_rd_cnt_q, cal_rd_cnt_d;
   logic [15:0] cal_wr_cnt_q, cal_wr_cnt_d;

   logic cal_active;
   logic dbg_issue;

   // issue_arm_q is only set while sitting in ISSUE with a saturated idle count,
   // so gating it with the live strobes gives the issue window without any
   // combinational path from the idle counter.
   assign cal_active = cal_read | cal_write;
   assign dbg_issue  = issue_arm_q & ~cal_active;

   assign cal_rdata         = emif_calbus_rdata;
   assign cal_seq_param_tbl = emif_calbus_seq_param_tbl;
   assign dbg_busy          = dbg_busy_q;
   assign dbg_ack           = dbg_ack_q;
   assign dbg_rdata         = dbg_rdata_q;
   assign cal_rd_cnt        = cal_rd_cnt_q;
   assign cal_wr_cnt        = cal_wr_cnt_q;

   // EMIF command mux: calibration always wins, debug only in its issue cycle.
   always_comb begin
      emif_calbus_read    = cal_read;
      emif_calbus_write   = cal_write;
      emif_calbus_address = cal_address;
      emif_calbus_wdata   = cal_wdata;
      if (dbg_issue) begin
         emif_calbus_read    = ~dbg_wr_q;
         emif_calbus_write   = dbg_wr_q;
         emif_calbus_address = dbg_addr_q;
         emif_calbus_wdata   = dbg_wdata_q;
      end
   end

   // Idle-gap tracking and saturating calibration traffic counters.
   always_comb begin
      if (cal_active) begin
         idle_cnt_d = 8'd0;
      end else if (idle_cnt_q == GAP) begin
         idle_cnt_d = idle_cnt_q;
      end else begin
         idle_cnt_d = idle_cnt_q + 8'd1;
      end
      cal_rd_cnt_d = cal_rd_cnt_q;
      if (cal_read && (cal_rd_cnt_q != 16'hFFFF)) begin
         cal_rd_cnt_d = cal_rd_cnt_q + 16'd1;
      end
      cal_wr_cnt_d = cal_wr_cnt_q;
      if (cal_write && (cal_wr_cnt_q != 16'hFFFF)) begin
         cal_wr_cnt_d = cal_wr_cnt_q + 16'd1;
      end
   end

   // Debug access sequencing: accept, wait for a gap, issue, wait for read data, ack.
   always_comb begin
      state_d     = state_q;
      lat_cnt_d   = lat_cnt_q;
      dbg_wr_d    = dbg_wr_q;
      dbg_addr_d  = dbg_addr_q;
      dbg_wdata_d = dbg_wdata_q;
      dbg_rdata_d = dbg_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (dbg_req) begin
               dbg_wr_d    = dbg_wr;
               dbg_addr_d  = dbg_addr;
               dbg_wdata_d = dbg_wdata;
               state_d     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (dbg_issue) begin
               if (dbg_wr_q) begin
                  state_d = ST_DONE;
               end else begin
                  lat_cnt_d = LAT_INIT;
                  state_d   = ST_RDWAIT;
               end
            end
         end
         ST_RDWAIT: begin
            if (lat_cnt_q == 4'd0) begin
               dbg_rdata_d = emif_calbus_rdata;
               state_d     = ST_DONE;
            end else begin
               lat_cnt_d = lat_cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      dbg_busy_d  = (state_d != ST_IDLE);
      dbg_ack_d   = (state_d == ST_DONE);
      issue_arm_d = (state_d == ST_ISSUE) && (idle_cnt_d == GAP);
   end

   // State registers with synchronous active-low reset; reset drops any in-flight access.
   always_ff @(posedge calbus_clk) begin
      if (!calbus_rst_n) begin
         state_q      <= ST_IDLE;
         idle_cnt_q   <= 8'd0;
         lat_cnt_q    <= 4'd0;
         dbg_wr_q     <= 1'b0;
         dbg_addr_q   <= 20'd0;
         dbg_wdata_q  <= 32'd0;
         dbg_rdata_q  <= 32'd0;
         dbg_busy_q   <= 1'b0;
         dbg_ack_q    <= 1'b0;
         issue_arm_q  <= 1'b0;
         cal_rd_cnt_q <= 16'd0;
         cal_wr_cnt_q <= 16'd0;
      end else begin
         state_q      <= state_d;
         idle_cnt_q   <= idle_cnt_d;
         lat_cnt_q    <= lat_cnt_d;
         dbg_wr_q     <= dbg_wr_d;
         dbg_addr_q   <= dbg_addr_d;
         dbg_wdata_q  <= dbg_wdata_d;
         dbg_rdata_q  <= dbg_rdata_d;
         dbg_busy_q   <= dbg_busy_d;
         dbg_ack_q    <= dbg_ack_d;
         issue_arm_q  <= issue_arm_d;
         cal_rd_cnt_q <= cal_rd_cnt_d;
         cal_wr_cnt_q <= cal_wr_cnt_d;
      end
   end

endmodule

// File: tb/tb_emif_calbus_dbg_arb.sv
// tb_emif_calbus_dbg_arb: directed scenarios plus randomized traffic, checked
// every cycle against a transaction-level model of the arbiter.
module tb_emif_calbus_dbg_arb;

   localparam int RD_LAT   = 2;
   localparam int IDLE_GAP = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cal_read, cal_write;
   logic [19:0]   cal_address;
   logic [31:0]   cal_wdata;
   logic [31:0]   cal_rdata;
   logic [4095:0] cal_tbl;
   logic          emif_read, emif_write;
   logic [19:0]   emif_address;
   logic [31:0]   emif_wdata;
   logic [31:0]   emif_rdata;
   logic [4095:0] emif_tbl;
   logic          dbg_req, dbg_wr;
   logic [19:0]   dbg_addr;
   logic [31:0]   dbg_wdata;
   logic          dbg_busy, dbg_ack;
   logic [31:0]   dbg_rdata;
   logic [15:0]   cal_rd_cnt, cal_wr_cnt;

   always #5 clk = ~clk;

   emif_calbus_dbg_arb #(.RD_LAT(RD_LAT), .IDLE_GAP(IDLE_GAP)) dut (
      .calbus_clk                (clk),
      .calbus_rst_n              (rst_n),
      .cal_read                  (cal_read),
      .cal_write                 (cal_write),
      .cal_address               (cal_address),
      .cal_wdata                 (cal_wdata),
      .cal_rdata                 (cal_rdata),
      .cal_seq_param_tbl         (cal_tbl),
      .emif_calbus_read          (emif_read),
      .emif_calbus_write         (emif_write),
      .emif_calbus_address       (emif_address),
      .emif_calbus_wdata         (emif_wdata),
      .emif_calbus_rdata         (emif_rdata),
      .emif_calbus_seq_param_tbl (emif_tbl),
      .dbg_req                   (dbg_req),
      .dbg_wr                    (dbg_wr),
      .dbg_addr                  (dbg_addr),
      .dbg_wdata                 (dbg_wdata),
      .dbg_busy                  (dbg_busy),
      .dbg_ack                   (dbg_ack),
      .dbg_rdata                 (dbg_rdata),
      .cal_rd_cnt                (cal_rd_cnt),
      .cal_wr_cnt                (cal_wr_cnt)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // Model: one debug transaction described by when it issues, captures and acks.
   bit          m_valid = 1'b0;
   int          m_idle, m_rd, m_wr;
   logic [31:0] m_rdata;
   bit          t_act, t_iss, t_wr;
   logic [19:0] t_addr;
   logic [31:0] t_wdata;
   int          t_ack_cyc, t_cap_cyc;
   int          m_issue_cyc = -1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   task automatic fill_tbl();
      for (int i = 0; i < 128; i++) emif_tbl[i*32 +: 32] = $urandom;
   endtask

   task automatic quiet();
      rst_n      = 1'b1;
      cal_read   = 1'b0;
      cal_write  = 1'b0;
      dbg_req    = 1'b0;
      emif_rdata = $urandom;
   endtask

   // One clock cycle: compare at negedge, advance model, then move to posedge+1.
   task automatic step();
      bit cal_act, issue_now, exp_rd, exp_wr;
      @(negedge clk);
      cal_act   = cal_read | cal_write;
      issue_now = t_act && !t_iss && (m_idle == IDLE_GAP) && !cal_act;
      if (m_valid) begin
         exp_rd = cal_act ? cal_read  : (issue_now && !t_wr);
         exp_wr = cal_act ? cal_write : (issue_now &&  t_wr);
         chk("emif_read", emif_read, exp_rd);
         chk("emif_write", emif_write, exp_wr);
         if (exp_rd || exp_wr) chk("emif_address", emif_address, cal_act ? cal_address : t_addr);
         if (exp_wr) chk("emif_wdata", emif_wdata, cal_act ? cal_wdata : t_wdata);
         chk("cal_rdata", cal_rdata, emif_rdata);
         n_vec++;
         if (cal_tbl !== emif_tbl) begin
            n_err++;
            $display("[TB] FAIL param_tbl at cycle %0d: got low word %h expected %h",
                     cyc, cal_tbl[31:0], emif_tbl[31:0]);
         end
         chk("dbg_busy", dbg_busy, t_act);
         chk("dbg_ack", dbg_ack, t_act && t_iss && (cyc == t_ack_cyc));
         chk("dbg_rdata", dbg_rdata, m_rdata);
         chk("cal_rd_cnt", cal_rd_cnt, m_rd[15:0]);
         chk("cal_wr_cnt", cal_wr_cnt, m_wr[15:0]);
      end
      if (!rst_n) begin
         m_valid = 1'b1;
         m_idle  = 0;
         m_rd    = 0;
         m_wr    = 0;
         m_rdata = 32'd0;
         t_act   = 1'b0;
         t_iss   = 1'b0;
      end else if (m_valid) begin
         if (t_act && t_iss && !t_wr && (cyc == t_cap_cyc)) m_rdata = emif_rdata;
         if (t_act && t_iss && (cyc == t_ack_cyc)) begin
            t_act = 1'b0;
         end else if (!t_act && dbg_req) begin
            t_act   = 1'b1;
            t_iss   = 1'b0;
            t_wr    = dbg_wr;
            t_addr  = dbg_addr;
            t_wdata = dbg_wdata;
         end else if (issue_now) begin
            t_iss       = 1'b1;
            m_issue_cyc = cyc;
            t_cap_cyc   = cyc + RD_LAT;
            t_ack_cyc   = t_wr ? cyc + 1 : cyc + RD_LAT + 1;
         end
         if (cal_read  && m_rd < 65535) m_rd++;
         if (cal_write && m_wr < 65535) m_wr++;
         m_idle = cal_act ? 0 : ((m_idle < IDLE_GAP) ? m_idle + 1 : IDLE_GAP);
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int last_cal, mark;
      quiet();
      fill_tbl();
      cal_address = 20'd0;
      cal_wdata   = 32'd0;
      dbg_wr      = 1'b0;
      dbg_addr    = 20'd0;
      dbg_wdata   = 32'd0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      step();
      step();

      // Passthrough write
      quiet();
      cal_write   = 1'b1;
      cal_address = 20'h00010;
      cal_wdata   = 32'hDEADBEEF;
      #1;
      chk("pass_write", emif_write, 1'b1);
      chk("pass_read", emif_read, 1'b0);
      chk("pass_addr", emif_address, 20'h00010);
      chk("pass_wdata", emif_wdata, 32'hDEADBEEF);
      step();
      quiet();
      chk("pass_wr_cnt", cal_wr_cnt, 16'd1);
      chk("pass_no_busy", dbg_busy, 1'b0);
      for (int i = 0; i < 6; i++) begin quiet(); step(); end

      // Debug read in a quiet window
      quiet();
      dbg_req  = 1'b1;
      dbg_wr   = 1'b0;
      dbg_addr = 20'h00200;
      step();
      quiet();
      #1;
      chk("dbgrd_strobe", emif_read, 1'b1);
      chk("dbgrd_addr", emif_address, 20'h00200);
      step();
      quiet();
      chk("dbgrd_noack_early", dbg_ack, 1'b0);
      step();
      quiet();
      emif_rdata = 32'h12345678;
      step();
      quiet();
      chk("dbgrd_ack", dbg_ack, 1'b1);
      chk("dbgrd_data", dbg_rdata, 32'h12345678);
      step();
      for (int i = 0; i < 4; i++) begin quiet(); step(); end

      // Collision: calibration read every third cycle starves the debug write
      last_cal = 0;
      for (int i = 0; i < 30; i++) begin
         quiet();
         cal_read    = (i % 3 == 0);
         cal_address = 20'($urandom);
         if (i == 0) begin
            dbg_req   = 1'b1;
            dbg_wr    = 1'b1;
            dbg_addr  = 20'h00321;
            dbg_wdata = 32'hA5A5_0F0F;
         end
         if (cal_read) last_cal = cyc;
         if (i == 29) chk("collide_busy", dbg_busy, 1'b1);
         step();
      end
      for (int i = 0; i < 12; i++) begin quiet(); step(); end
      chk("collide_issue_gap", 32'(m_issue_cyc - last_cal), 32'(IDLE_GAP + 1));

      // Issue-cycle contention: cal_write lands on the first gap cycle
      quiet();
      cal_read = 1'b1;
      dbg_req  = 1'b1;
      dbg_wr   = 1'b0;
      dbg_addr = 20'h00ABC;
      step();
      for (int i = 0; i < 4; i++) begin quiet(); step(); end
      quiet();
      cal_write   = 1'b1;
      cal_address = 20'h00077;
      cal_wdata   = 32'h0000_7777;
      #1;
      chk("contend_fwd_wr", emif_write, 1'b1);
      chk("contend_fwd_rd", emif_read, 1'b0);
      chk("contend_fwd_addr", emif_address, 20'h00077);
      mark = cyc;
      step();
      for (int i = 0; i < 12; i++) begin quiet(); step(); end
      chk("contend_issue_gap", 32'(m_issue_cyc - mark), 32'(IDLE_GAP + 1));

      // Reset during RDWAIT
      for (int i = 0; i < 4; i++) begin quiet(); step(); end
      quiet();
      dbg_req  = 1'b1;
      dbg_wr   = 1'b0;
      dbg_addr = 20'h00300;
      step();
      quiet();
      step();
      quiet();
      rst_n = 1'b0;
      step();
      quiet();
      chk("rst_busy", dbg_busy, 1'b0);
      chk("rst_ack", dbg_ack, 1'b0);
      chk("rst_rdata", dbg_rdata, 32'd0);
      chk("rst_rd_cnt", cal_rd_cnt, 16'd0);
      chk("rst_wr_cnt", cal_wr_cnt, 16'd0);
      for (int i = 0; i < 5; i++) begin quiet(); step(); end
      quiet();
      dbg_req  = 1'b1;
      dbg_wr   = 1'b0;
      dbg_addr = 20'h00400;
      step();
      quiet(); step();
      quiet(); step();
      quiet();
      emif_rdata = 32'hCAFEF00D;
      step();
      quiet();
      chk("post_rst_ack", dbg_ack, 1'b1);
      chk("post_rst_data", dbg_rdata, 32'hCAFEF00D);
      step();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bit cal_on;
         rst_n       = ($urandom_range(0, 199) != 0);
         cal_on      = ($urandom_range(0, 99) < 25);
         cal_read    = cal_on && ($urandom_range(0, 1) == 1);
         cal_write   = cal_on && ($urandom_range(0, 2) != 0);
         cal_address = 20'($urandom);
         cal_wdata   = $urandom;
         emif_rdata  = $urandom;
         dbg_req     = ($urandom_range(0, 3) == 0);
         dbg_wr      = $urandom_range(0, 1) == 1;
         dbg_addr    = 20'($urandom);
         dbg_wdata   = $urandom;
         if (i % 500 == 0) fill_tbl();
         step();
      end
      for (int i = 0; i < 20; i++) begin quiet(); step(); end

      // Read-counter saturation
      for (int i = 0; i < 70000; i++) begin
         quiet();
         cal_read    = 1'b1;
         cal_address = 20'($urandom);
         step();
      end
      quiet();
      chk("sat_rd_cnt", cal_rd_cnt, 16'hFFFF);
      for (int i = 0; i < 5; i++) begin
         quiet();
         cal_read = 1'b1;
         step();
      end
      quiet();
      chk("sat_no_wrap", cal_rd_cnt, 16'hFFFF);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
